// File: rtl/axi_lite_wr_capture_pkg.sv
// Shared types and constants for the AXI4-Lite write-capture block.
// Holds the FSM state encoding, the BRESP codes and the FIFO entry width helper.
package axi_lite_wr_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/axi_lite_wr_capture.sv
// AXI4-Lite write slave that captures one address/data pair at a time and
// pushes {addr, data, strb} into a downstream FIFO, then issues the B response.
//
// state | meaning
// IDLE  | collecting AW and W beats independently
// PUSH  | waiting for FIFO room, then one-cycle push strobe
// RESP  | BVALID held with BRESP until the master takes it
module axi_lite_wr_capture
  import axi_lite_wr_capture_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 16'h0FFF
) (
  input  logic                                              ACLK,
  input  logic                                              ARESET_N,
  input  logic                                              AWVALID,
  output logic                                              AWREADY,
  input  logic [ADDR_WIDTH-1:0]                             AWADDR,
  input  logic                                              WVALID,
  output logic                                              WREADY,
  input  logic [DATA_WIDTH-1:0]                             WDATA,
  input  logic [DATA_WIDTH/8-1:0]                           WSTRB,
  output logic                                              BVALID,
  input  logic                                              BREADY,
  output logic [1:0]                                        BRESP,
  output logic                                              FIFO_WR_EN,
  output logic [entry_width(ADDR_WIDTH, DATA_WIDTH)-1:0]    FIFO_DATA,
  input  logic                                              FIFO_FULL
);

  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int ENTRY_WIDTH = entry_width(ADDR_WIDTH, DATA_WIDTH);

  state_e                   state_q, state_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [STRB_WIDTH-1:0]    strb_q, strb_d;
  logic                     awready_q, awready_d;
  logic                     wready_q, wready_d;
  logic                     bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;
  logic                     fifo_wr_en_q, fifo_wr_en_d;
  logic [ENTRY_WIDTH-1:0]   fifo_data_q, fifo_data_d;
  logic                     aw_hs, w_hs;

  assign aw_hs = AWVALID & awready_q;
  assign w_hs  = WVALID & wready_q;

  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    addr_d       = addr_q;
    data_d       = data_q;
    strb_d       = strb_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    fifo_wr_en_d = 1'b0;
    fifo_data_d  = fifo_data_q;

    case (state_q)
      IDLE: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_hs) addr_d = AWADDR;
        if (w_hs) begin
          data_d = WDATA;
          strb_d = WSTRB;
        end
        if (aw_done_d && w_done_d) begin
          awready_d = 1'b0;
          wready_d  = 1'b0;
          if (addr_d > ADDR_LIMIT) begin
            state_d  = RESP;
            bvalid_d = 1'b1;
            bresp_d  = SLVERR;
          end else begin
            state_d      = PUSH;
            fifo_data_d  = {addr_d, data_d, strb_d};
            fifo_wr_en_d = ~FIFO_FULL;
          end
        end else begin
          // Ready comes back one cycle after reset release, then drops per channel once captured.
          awready_d = ~aw_done_d;
          wready_d  = ~w_done_d;
        end
      end

      PUSH: begin
        if (fifo_wr_en_q) begin
          state_d  = RESP;
          bvalid_d = 1'b1;
          bresp_d  = OKAY;
        end else begin
          fifo_wr_en_d = ~FIFO_FULL;
        end
      end

      RESP: begin
        if (BREADY) begin
          state_d   = IDLE;
          bvalid_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      state_q      <= IDLE;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= OKAY;
      fifo_wr_en_q <= 1'b0;
      fifo_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      fifo_data_q  <= fifo_data_d;
    end
  end

  assign AWREADY    = awready_q;
  assign WREADY     = wready_q;
  assign BVALID     = bvalid_q;
  assign BRESP      = bresp_q;
  assign FIFO_WR_EN = fifo_wr_en_q;
  assign FIFO_DATA  = fifo_data_q;

endmodule

// File: tb/tb_axi_lite_wr_capture.sv
// Directed bench for axi_lite_wr_capture: stimulus pushes expected FIFO entries
// and responses into queues; a negedge monitor pops and compares them.
module tb_axi_lite_wr_capture;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int EW = AW + DW + SW;

  logic          ACLK = 1'b0;
  logic          ARESET_N;
  logic          AWVALID, AWREADY;
  logic [AW-1:0] AWADDR;
  logic          WVALID, WREADY;
  logic [DW-1:0] WDATA;
  logic [SW-1:0] WSTRB;
  logic          BVALID, BREADY;
  logic [1:0]    BRESP;
  logic          FIFO_WR_EN;
  logic [EW-1:0] FIFO_DATA;
  logic          FIFO_FULL;

  axi_lite_wr_capture #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ADDR_LIMIT(16'h0FFF)
  ) dut (
    .ACLK(ACLK), .ARESET_N(ARESET_N),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .FIFO_WR_EN(FIFO_WR_EN), .FIFO_DATA(FIFO_DATA), .FIFO_FULL(FIFO_FULL)
  );

  always #5 ACLK = ~ACLK;

  int n_pass = 0;
  int n_total = 0;
  int push_count = 0;
  int resp_count = 0;
  logic [EW-1:0] push_q[$];
  logic [1:0]    resp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
  endtask

  // Monitor: compares every push and every completed response against the queues.
  always @(negedge ACLK) begin
    if (ARESET_N === 1'b1) begin
      if (FIFO_WR_EN === 1'b1) begin
        push_count++;
        chk("push_while_full", {63'd0, FIFO_FULL}, 64'd0);
        if (push_q.size() == 0) chk("unexpected_push", 64'd1, 64'd0);
        else chk("fifo_data", {12'd0, FIFO_DATA}, {12'd0, push_q.pop_front()});
      end
      if (BVALID === 1'b1 && BREADY === 1'b1) begin
        resp_count++;
        if (resp_q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
        else chk("bresp", {62'd0, BRESP}, {62'd0, resp_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  // Present the selected channels and hold until their handshake edge; returns just after it.
  task automatic send(input logic do_aw, input logic do_w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s);
    bit ok = 0;
    AWVALID = do_aw; AWADDR = a;
    WVALID  = do_w;  WDATA  = d; WSTRB = s;
    for (int i = 0; i < 20; i++) begin
      if ((!do_aw || AWREADY) && (!do_w || WREADY)) begin
        ok = 1;
        cyc();
        break;
      end
      cyc();
    end
    if (!ok) chk("handshake_timeout", 64'd1, 64'd0);
    AWVALID = 1'b0;
    WVALID  = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int start);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_count > start) begin
        ok = 1;
        break;
      end
      cyc();
    end
    if (!ok) $display("FAIL %s: response timeout got=none expected=resp", name);
    if (!ok) n_total++;
  endtask

  initial begin
    int p0, r0;
    ARESET_N = 1'b0;
    AWVALID = 0; AWADDR = '0; WVALID = 0; WDATA = '0; WSTRB = '0;
    BREADY = 1'b1; FIFO_FULL = 1'b0;

    repeat (3) cyc();
    chk("rst_awready", {63'd0, AWREADY}, 64'd0);
    chk("rst_bvalid", {63'd0, BVALID}, 64'd0);
    chk("rst_fifo_data", {12'd0, FIFO_DATA}, 64'd0);
    ARESET_N = 1'b1;
    cyc();
    chk("post_rst_awready", {63'd0, AWREADY}, 64'd1);
    chk("post_rst_wready", {63'd0, WREADY}, 64'd1);

    // AW and W together, FIFO empty: push at N+1, OKAY at N+2.
    p0 = push_count; r0 = resp_count;
    push_q.push_back({16'h0010, 32'hDEADBEEF, 4'hF});
    resp_q.push_back(2'b00);
    send(1, 1, 16'h0010, 32'hDEADBEEF, 4'hF);
    chk("t1_wr_en_n1", {63'd0, FIFO_WR_EN}, 64'd1);
    chk("t1_awready_low", {63'd0, AWREADY}, 64'd0);
    cyc();
    chk("t1_bvalid_n2", {63'd0, BVALID}, 64'd1);
    chk("t1_bresp_n2", {62'd0, BRESP}, 64'd0);
    chk("t1_wr_en_n2", {63'd0, FIFO_WR_EN}, 64'd0);
    cyc();
    chk("t1_bvalid_done", {63'd0, BVALID}, 64'd0);
    chk("t1_ready_back", {62'd0, AWREADY, WREADY}, 64'd3);
    chk("t1_push_once", push_count - p0, 64'd1);
    chk("t1_resp_once", resp_count - r0, 64'd1);

    // W first, AW three cycles later.
    p0 = push_count; r0 = resp_count;
    push_q.push_back({16'h0020, 32'h12345678, 4'h3});
    resp_q.push_back(2'b00);
    send(0, 1, '0, 32'h12345678, 4'h3);
    chk("t2_wready_n1", {63'd0, WREADY}, 64'd0);
    chk("t2_awready_n1", {63'd0, AWREADY}, 64'd1);
    chk("t2_no_push_n1", {63'd0, FIFO_WR_EN}, 64'd0);
    cyc();
    chk("t2_wready_n2", {63'd0, WREADY}, 64'd0);
    cyc();
    send(1, 0, 16'h0020, '0, '0);
    chk("t2_wr_en_n4", {63'd0, FIFO_WR_EN}, 64'd1);
    chk("t2_wready_n4", {63'd0, WREADY}, 64'd0);
    wait_resp("t2", r0);
    cyc();
    chk("t2_push_once", push_count - p0, 64'd1);

    // AW first, W later, partial strobe.
    p0 = push_count; r0 = resp_count;
    push_q.push_back({16'h0ABC, 32'hA5A5_0F0F, 4'h8});
    resp_q.push_back(2'b00);
    send(1, 0, 16'h0ABC, '0, '0);
    chk("t3_awready_low", {63'd0, AWREADY}, 64'd0);
    cyc();
    send(0, 1, '0, 32'hA5A5_0F0F, 4'h8);
    wait_resp("t3", r0);
    cyc();
    chk("t3_push_once", push_count - p0, 64'd1);

    // FIFO full for 5 cycles in PUSH.
    p0 = push_count; r0 = resp_count;
    push_q.push_back({16'h0100, 32'hCAFEF00D, 4'h5});
    resp_q.push_back(2'b00);
    FIFO_FULL = 1'b1;
    send(1, 1, 16'h0100, 32'hCAFEF00D, 4'h5);
    for (int i = 0; i < 5; i++) begin
      chk("t4_wr_en_full", {63'd0, FIFO_WR_EN}, 64'd0);
      chk("t4_no_bvalid", {63'd0, BVALID}, 64'd0);
      cyc();
    end
    FIFO_FULL = 1'b0;
    wait_resp("t4", r0);
    cyc();
    chk("t4_push_once", push_count - p0, 64'd1);

    // Above limit: SLVERR, no push.
    p0 = push_count; r0 = resp_count;
    resp_q.push_back(2'b10);
    send(1, 1, 16'h1000, 32'h11111111, 4'hF);
    chk("t5_slverr_bvalid", {63'd0, BVALID}, 64'd1);
    chk("t5_slverr_code", {62'd0, BRESP}, 64'd2);
    wait_resp("t5", r0);
    cyc();
    chk("t5_no_push", push_count - p0, 64'd0);

    // Far above limit checks the full-width unsigned compare.
    p0 = push_count; r0 = resp_count;
    resp_q.push_back(2'b10);
    send(1, 1, 16'hF000, 32'h22222222, 4'hF);
    wait_resp("t5b", r0);
    cyc();
    chk("t5b_no_push", push_count - p0, 64'd0);

    // Exactly the limit: accepted.
    p0 = push_count; r0 = resp_count;
    push_q.push_back({16'h0FFF, 32'h0BADF00D, 4'hF});
    resp_q.push_back(2'b00);
    send(1, 1, 16'h0FFF, 32'h0BADF00D, 4'hF);
    wait_resp("t6", r0);
    cyc();
    chk("t6_push_once", push_count - p0, 64'd1);

    // BREADY held low 4 cycles.
    r0 = resp_count;
    push_q.push_back({16'h0044, 32'h44444444, 4'hC});
    resp_q.push_back(2'b00);
    BREADY = 1'b0;
    send(1, 1, 16'h0044, 32'h44444444, 4'hC);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("t7_bvalid_hold", {63'd0, BVALID}, 64'd1);
      chk("t7_bresp_hold", {62'd0, BRESP}, 64'd0);
      chk("t7_ready_low", {62'd0, AWREADY, WREADY}, 64'd0);
      cyc();
    end
    BREADY = 1'b1;
    cyc();
    chk("t7_bvalid_clear", {63'd0, BVALID}, 64'd0);
    chk("t7_ready_back", {62'd0, AWREADY, WREADY}, 64'd3);
    chk("t7_resp_once", resp_count - r0, 64'd1);

    // Reset while stalled in PUSH: transaction discarded.
    p0 = push_count; r0 = resp_count;
    FIFO_FULL = 1'b1;
    send(1, 1, 16'h0055, 32'h55555555, 4'hF);
    cyc();
    ARESET_N = 1'b0;
    #1;
    chk("t8_rst_wr_en", {63'd0, FIFO_WR_EN}, 64'd0);
    chk("t8_rst_ready", {62'd0, AWREADY, WREADY}, 64'd0);
    chk("t8_rst_bvalid", {63'd0, BVALID}, 64'd0);
    chk("t8_rst_data", {12'd0, FIFO_DATA}, 64'd0);
    cyc();
    ARESET_N = 1'b1;
    FIFO_FULL = 1'b0;
    cyc();
    chk("t8_ready_after", {62'd0, AWREADY, WREADY}, 64'd3);
    repeat (10) cyc();
    chk("t8_no_push", push_count - p0, 64'd0);
    chk("t8_no_resp", resp_count - r0, 64'd0);

    chk("push_q_drained", push_q.size(), 64'd0);
    chk("resp_q_drained", resp_q.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
